// File: rtl/dmem_pkg.sv
// Shared types, requester indices and byte-merge helper for the data memory arbiter.
package dmem_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } dmem_state_e;

   localparam int REQ_CORE    = 0;
   localparam int REQ_DMA     = 1;
   localparam int DMEM_DATA_W = 32;
   localparam int DMEM_BE_W   = DMEM_DATA_W / 8;

   // Per byte, take the new byte where enabled, otherwise keep the stored byte.
   function automatic logic [DMEM_DATA_W-1:0] merge_bytes(
      input logic [DMEM_DATA_W-1:0] old_word,
      input logic [DMEM_DATA_W-1:0] new_word,
      input logic [DMEM_BE_W-1:0]   be
   );
      logic [DMEM_DATA_W-1:0] merged;
      for (int b = 0; b < DMEM_BE_W; b++) begin
         merged[b*8 +: 8] = be[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bus of both requesters plus the word-wide memory port.
interface dmem_arbiter_if
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = DMEM_DATA_W,
   parameter int MEM_DEPTH  = 1024
);
   localparam int MEM_AW = $clog2(MEM_DEPTH);
   localparam int BE_W   = DATA_WIDTH / 8;

   logic [1:0]                 req_valid;
   logic [1:0]                 req_ready;
   logic [1:0]                 req_we;
   logic [1:0][ADDR_WIDTH-1:0] req_addr;
   logic [1:0][DATA_WIDTH-1:0] req_wdata;
   logic [1:0][BE_W-1:0]       req_be;
   logic [1:0]                 resp_valid;
   logic [DATA_WIDTH-1:0]      resp_rdata;
   logic                       resp_err;
   logic [MEM_AW-1:0]          mem_addr;
   logic                       mem_we;
   logic [DATA_WIDTH-1:0]      mem_wd;
   logic [DATA_WIDTH-1:0]      mem_rd;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, mem_rd,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wd
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, mem_rd,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wd
   );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; a tie goes to whoever was not granted last.
module rr_arbiter2
   import dmem_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic last_grant;

   // One-hot grant: a lone requester wins outright, a tie alternates.
   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = last_grant ? 2'b01 : 2'b10;
      end
   end

   // Remember the most recent winner; resets to the DMA side so the core wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= 1'b1;
      end else if (advance && (grant != 2'b00)) begin
         last_grant <= grant[REQ_DMA];
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one word-organised data memory between the core and the DMA/debug port,
// turning byte-enabled writes into read-modify-write sequences.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = DMEM_DATA_W,
   parameter int MEM_DEPTH  = 1024
)(
   input  logic          clk,
   input  logic          reset,
   dmem_arbiter_if.slave bus
);

   localparam int MEM_AW = $clog2(MEM_DEPTH);
   localparam int BE_W   = DATA_WIDTH / 8;

   dmem_state_e state;
   logic        owner;
   logic [MEM_AW-1:0]     rmw_addr;
   logic [DATA_WIDTH-1:0] rmw_data;

   logic [1:0]  arb_req;
   logic [1:0]  grant;
   logic        arb_en;
   logic        accept;
   logic        sel;
   logic        cur_we;
   logic [ADDR_WIDTH-3:0] word_idx;
   logic [DATA_WIDTH-1:0] cur_wdata;
   logic [BE_W-1:0]       cur_be;
   logic        oor;
   logic        be_full;
   logic        be_part;
   logic        do_full;
   logic        do_part;

   logic [1:0]            resp_valid_q;
   logic [DATA_WIDTH-1:0] resp_rdata_q;
   logic                  resp_err_q;

   // Grants are only handed out while idle; the RMW write cycle blocks everyone.
   assign arb_en  = (state == IDLE);
   assign arb_req = bus.req_valid & {2{arb_en}};

   rr_arbiter2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (arb_req),
      .advance (arb_en),
      .grant   (grant)
   );

   // Decode the granted request.
   always_comb begin
      accept    = (grant != 2'b00);
      sel       = grant[REQ_DMA];
      cur_we    = bus.req_we[sel];
      word_idx  = bus.req_addr[sel][ADDR_WIDTH-1:2];
      cur_wdata = bus.req_wdata[sel];
      cur_be    = bus.req_be[sel];
      oor       = (word_idx > (ADDR_WIDTH-2)'(MEM_DEPTH - 1));
      be_full   = &cur_be;
      be_part   = (cur_be != '0) && !be_full;
      do_full   = accept && cur_we && !oor && be_full;
      do_part   = accept && cur_we && !oor && be_part;
   end

   // Memory port: RMW write-back has priority, otherwise the accepted in-range request; zero when idle.
   always_comb begin
      bus.mem_addr = '0;
      bus.mem_we   = 1'b0;
      bus.mem_wd   = '0;
      if (state == RMW_WR) begin
         bus.mem_addr = rmw_addr;
         bus.mem_we   = 1'b1;
         bus.mem_wd   = rmw_data;
      end else if (accept && !oor) begin
         bus.mem_addr = word_idx[MEM_AW-1:0];
         if (do_full) begin
            bus.mem_we = 1'b1;
            bus.mem_wd = cur_wdata;
         end
      end
   end

   // Control FSM with registered responses; an async reset drops any pending RMW silently.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         owner        <= 1'b0;
         resp_valid_q <= 2'b00;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         resp_valid_q <= 2'b00;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (do_part) begin
                  state <= RMW_WR;
                  owner <= sel;
               end else if (accept) begin
                  resp_valid_q <= grant;
                  resp_err_q   <= oor;
                  if (!cur_we && !oor) begin
                     resp_rdata_q <= bus.mem_rd;
                  end
               end
            end
            RMW_WR: begin
               state        <= IDLE;
               resp_valid_q <= owner ? 2'b10 : 2'b01;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // RMW word address and merged data, captured in the accept cycle of a partial write.
   always_ff @(posedge clk) begin
      if (do_part) begin
         rmw_addr <= word_idx[MEM_AW-1:0];
         rmw_data <= merge_bytes(bus.mem_rd, cur_wdata, cur_be);
      end
   end

   assign bus.req_ready  = grant;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reads, round-robin ties, full/empty/partial writes,
// out-of-range accesses and reset during a read-modify-write.
module tb_dmem_arbiter;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024)) bus ();

   dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.req_valid = 2'b00;
      bus.req_we    = 2'b00;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_be    = '0;
      bus.mem_rd    = '0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      idle_inputs();

      // reset state
      #2;
      chk("rst_ready", bus.req_ready, 2'b00);
      chk("rst_resp_valid", bus.resp_valid, 2'b00);
      chk("rst_rdata", bus.resp_rdata, 32'h0);
      chk("rst_err", bus.resp_err, 1'b0);
      chk("rst_mem_we", bus.mem_we, 1'b0);
      chk("rst_mem_addr", bus.mem_addr, 10'd0);
      @(negedge clk);
      reset = 1'b0;

      // requester 0 read at 0x10
      bus.req_valid   = 2'b01;
      bus.req_we[0]   = 1'b0;
      bus.req_addr[0] = 32'h10;
      bus.mem_rd      = 32'hDEADBEEF;
      #1;
      chk("rd_ready", bus.req_ready, 2'b01);
      chk("rd_mem_addr", bus.mem_addr, 10'd4);
      chk("rd_mem_we", bus.mem_we, 1'b0);
      @(posedge clk); #1;
      chk("rd_resp_valid", bus.resp_valid, 2'b01);
      chk("rd_rdata", bus.resp_rdata, 32'hDEADBEEF);
      chk("rd_err", bus.resp_err, 1'b0);

      // fresh reset, then both requesters read every cycle
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         bus.req_valid   = 2'b11;
         bus.req_we      = 2'b00;
         bus.req_addr[0] = 32'h20;
         bus.req_addr[1] = 32'h40;
         bus.mem_rd      = 32'h12345678;
         #1;
         chk("rr_ready", bus.req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
         chk("rr_mem_addr", bus.mem_addr, (i % 2 == 0) ? 10'd8 : 10'd16);
         @(posedge clk); #1;
         chk("rr_resp_valid", bus.resp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
         chk("rr_rdata", bus.resp_rdata, 32'h12345678);
      end

      // requester 1 partial write, byte 1 only
      @(negedge clk);
      idle_inputs();
      bus.req_valid    = 2'b10;
      bus.req_we[1]    = 1'b1;
      bus.req_addr[1]  = 32'h8;
      bus.req_be[1]    = 4'b0010;
      bus.req_wdata[1] = 32'h0000AB00;
      bus.mem_rd       = 32'h11223344;
      #1;
      chk("pw_ready", bus.req_ready, 2'b10);
      chk("pw_acc_mem_we", bus.mem_we, 1'b0);
      chk("pw_acc_mem_addr", bus.mem_addr, 10'd2);
      @(posedge clk); #1;
      chk("pw_wr_mem_we", bus.mem_we, 1'b1);
      chk("pw_wr_mem_addr", bus.mem_addr, 10'd2);
      chk("pw_wr_mem_wd", bus.mem_wd, 32'h1122AB44);
      chk("pw_wr_resp_valid", bus.resp_valid, 2'b00);
      @(negedge clk);
      bus.req_valid   = 2'b01;
      bus.req_we[0]   = 1'b0;
      bus.req_addr[0] = 32'h10;
      #1;
      chk("pw_wr_ready", bus.req_ready, 2'b00);
      chk("pw_wr_mem_we_hold", bus.mem_we, 1'b1);
      @(posedge clk); #1;
      chk("pw_resp_valid", bus.resp_valid, 2'b10);
      chk("pw_rdata", bus.resp_rdata, 32'h0);
      chk("pw_err", bus.resp_err, 1'b0);
      chk("pw_next_ready", bus.req_ready, 2'b01);
      chk("pw_next_mem_we", bus.mem_we, 1'b0);
      chk("pw_next_mem_addr", bus.mem_addr, 10'd4);
      @(posedge clk); #1;
      chk("pw_next_resp_valid", bus.resp_valid, 2'b01);
      chk("pw_next_rdata", bus.resp_rdata, 32'h11223344);

      // requester 0 full write
      @(negedge clk);
      idle_inputs();
      bus.req_valid    = 2'b01;
      bus.req_we[0]    = 1'b1;
      bus.req_addr[0]  = 32'h4;
      bus.req_be[0]    = 4'hF;
      bus.req_wdata[0] = 32'hCAFEF00D;
      #1;
      chk("fw_ready", bus.req_ready, 2'b01);
      chk("fw_mem_we", bus.mem_we, 1'b1);
      chk("fw_mem_addr", bus.mem_addr, 10'd1);
      chk("fw_mem_wd", bus.mem_wd, 32'hCAFEF00D);
      @(posedge clk); #1;
      chk("fw_resp_valid", bus.resp_valid, 2'b01);
      chk("fw_rdata", bus.resp_rdata, 32'h0);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("idle_mem_we", bus.mem_we, 1'b0);
      chk("idle_mem_addr", bus.mem_addr, 10'd0);
      chk("idle_mem_wd", bus.mem_wd, 32'h0);

      // requester 1 empty write
      bus.req_valid    = 2'b10;
      bus.req_we[1]    = 1'b1;
      bus.req_addr[1]  = 32'hC;
      bus.req_be[1]    = 4'h0;
      bus.req_wdata[1] = 32'hFFFFFFFF;
      #1;
      chk("ew_ready", bus.req_ready, 2'b10);
      chk("ew_mem_we", bus.mem_we, 1'b0);
      @(posedge clk); #1;
      chk("ew_resp_valid", bus.resp_valid, 2'b10);
      chk("ew_err", bus.resp_err, 1'b0);
      chk("ew_rdata", bus.resp_rdata, 32'h0);

      // out-of-range read by requester 0
      @(negedge clk);
      idle_inputs();
      bus.req_valid   = 2'b01;
      bus.req_addr[0] = 32'h1000;
      bus.mem_rd      = 32'hFFFFFFFF;
      #1;
      chk("oor_rd_ready", bus.req_ready, 2'b01);
      chk("oor_rd_mem_we", bus.mem_we, 1'b0);
      @(posedge clk); #1;
      chk("oor_rd_resp_valid", bus.resp_valid, 2'b01);
      chk("oor_rd_err", bus.resp_err, 1'b1);
      chk("oor_rd_rdata", bus.resp_rdata, 32'h0);

      // out-of-range full write by requester 1
      @(negedge clk);
      idle_inputs();
      bus.req_valid    = 2'b10;
      bus.req_we[1]    = 1'b1;
      bus.req_addr[1]  = 32'h2000;
      bus.req_be[1]    = 4'hF;
      bus.req_wdata[1] = 32'h55AA55AA;
      #1;
      chk("oor_wr_mem_we", bus.mem_we, 1'b0);
      @(posedge clk); #1;
      chk("oor_wr_resp_valid", bus.resp_valid, 2'b10);
      chk("oor_wr_err", bus.resp_err, 1'b1);

      // reset asserted while the RMW write-back is pending
      @(negedge clk);
      idle_inputs();
      bus.req_valid    = 2'b01;
      bus.req_we[0]    = 1'b1;
      bus.req_addr[0]  = 32'h8;
      bus.req_be[0]    = 4'b0001;
      bus.req_wdata[0] = 32'h000000AA;
      #1;
      chk("rmw_rst_ready", bus.req_ready, 2'b01);
      @(posedge clk); #1;
      chk("rmw_rst_pre_we", bus.mem_we, 1'b1);
      chk("rmw_rst_pre_wd", bus.mem_wd, 32'h000000AA);
      bus.req_valid = 2'b00;
      reset = 1'b1;
      #1;
      chk("rmw_rst_mem_we", bus.mem_we, 1'b0);
      chk("rmw_rst_mem_addr", bus.mem_addr, 10'd0);
      chk("rmw_rst_resp_valid", bus.resp_valid, 2'b00);
      @(posedge clk); #1;
      chk("rmw_rst_resp_valid2", bus.resp_valid, 2'b00);
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      bus.req_valid   = 2'b11;
      bus.req_addr[0] = 32'h10;
      bus.req_addr[1] = 32'h40;
      #1;
      chk("post_rst_tie_ready", bus.req_ready, 2'b01);
      @(posedge clk); #1;
      chk("post_rst_resp_valid", bus.resp_valid, 2'b01);

      @(negedge clk);
      idle_inputs();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-cycle core's word-organised data memory between two requesters: requester 0 (core load/store unit) and requester 1 (DMA/debug port). Arbitrates between them round-robin. Converts byte-enabled writes into read-modify-write sequences, because the memory has no byte strobes. Drives the memory's word address, write enable and write data, and returns registered read responses.

## Interface
- ADDR_WIDTH, 32, byte address width of requests
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- MEM_DEPTH, 1024, memory size in words; MEM_AW = $clog2(MEM_DEPTH)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  [1:0]  request valid per requester
- req_ready  out  [1:0]  request accepted this cycle (combinational)
- req_we  in  [1:0]  1 = write, 0 = read
- req_addr  in  [1:0][ADDR_WIDTH-1:0]  byte address; bits [1:0] ignored
- req_wdata  in  [1:0][DATA_WIDTH-1:0]  write data
- req_be  in  [1:0][DATA_WIDTH/8-1:0]  byte enables for writes; ignored on reads
- resp_valid  out  [1:0]  one-cycle response pulse per requester
- resp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- resp_err  out  1  out-of-range address, qualified by resp_valid
- mem_addr  out  MEM_AW  word index = req_addr[MEM_AW+1:2]
- mem_we  out  1  memory write enable
- mem_wd  out  DATA_WIDTH  memory write data
- mem_rd  in  DATA_WIDTH  asynchronous memory read data

## Operation
- FSM states: IDLE, RMW_WR.
- In IDLE, a requester is granted when its req_valid is high. If both are valid, the one not granted last wins. last_grant resets to 1, so requester 0 wins the first tie. req_ready is high only for the granted requester, and only in IDLE.
- Out of range: req_addr[ADDR_WIDTH-1:2] >= MEM_DEPTH. The request is accepted; mem_we stays 0; the response is returned with resp_err=1 and resp_rdata=0.
- Read: mem_addr is driven in the accept cycle. mem_rd is captured into resp_rdata. The state stays IDLE.
- Full write (be all ones): mem_we=1 and mem_wd=req_wdata in the accept cycle. The state stays IDLE.
- Empty write (be=0): accepted as a no-op with mem_we=0. Responds like a full write.
- Partial write:
  - Accept cycle: mem_we=0; the word address is latched; merged = per byte (be ? wdata : mem_rd); the owner is latched; the state goes to RMW_WR.
  - RMW_WR: mem_we=1, mem_wd=merged, mem_addr=latched; no grants; return to IDLE.
- mem_we is never high for more than one cycle per transaction. When no transaction is active, mem_addr and mem_wd are 0.
- Reset values: state=IDLE, last_grant=1, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0.
- Reset mid-RMW: the pending write is dropped (memory not written) and no response is issued.

## Timing
- Read, full write, empty write and error: accept at cycle T, resp_valid[i] at T+1. Back-to-back acceptance is possible every cycle.
- Partial write: accept at T, memory write at T+1, resp_valid[i] at T+2. No acceptance happens at T+1.
- Responses have no backpressure; the requester must take resp_valid when it arrives.
- req_* fields are sampled only in the accept cycle. A requester holds them stable while valid && !ready.
- The loser of a tie gets priority in the next IDLE cycle. Worst-case wait is 2 cycles, or 3 cycles if the winner's request is a partial write.

## Structure
- Package dmem_pkg holds:
  - state enum dmem_state_e {IDLE, RMW_WR}
  - REQ_CORE=0 and REQ_DMA=1 constants
  - function merge_bytes(old, new, be)
- Sub-module rr_arbiter2: two-requester round-robin with last_grant register and an advance enable. The FSM, merge logic and response registers stay in dmem_arbiter.

## Test plan
- Reset, then requester 0 reads addr 0x10 with mem_rd=0xDEADBEEF → ready[0] same cycle, mem_addr=4, resp_valid[0] next cycle with rdata 0xDEADBEEF, err=0.
- Both requesters valid every cycle with reads → grants alternate 0,1,0,1; first grant goes to 0.
- Requester 1 partial write addr 0x8, be=4'b0010, wdata=0x0000AB00, with mem_rd=0x11223344 → T+1: mem_we=1, mem_addr=2, mem_wd=0x1122AB44; resp_valid[1] at T+2; req_ready=0 at T+1.
- Full write be=4'hF, addr 0x4, wdata 0xCAFEF00D → mem_we=1 in the accept cycle, mem_wd=0xCAFEF00D, resp_valid at +1.
- Out-of-range read at addr 0x1000 with MEM_DEPTH=1024 → mem_we=0, resp_err=1, resp_rdata=0.
- reset asserted during RMW_WR → mem_we drops immediately, no resp_valid, state returns to IDLE, next tie granted to requester 0.
